// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch and decode stages: widths, opcodes,
// the fetch FSM encoding and the fetch FIFO entry layout.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x W synchronous FIFO with flush; flush wins over push in the same cycle.
// Storage is reset so the head reads as zero out of reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// in-order response buffering and redirect flush with stale-response discard.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr_word,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  output fetch_state_e dbg_state_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic          fifo_empty, fifo_full;
  logic          pop, push, grant, has_credit;

  // Handshakes: imem request completes on imem_req & imem_gnt; instruction
  // transfer completes on instr_valid & instr_ready; the payload of either
  // side is held stable while its valid is high and the transfer is pending.
  assign pop   = ~fifo_empty & instr_ready;
  assign grant = imem_req & imem_gnt;
  assign push  = imem_rvalid & (discard_q == '0) & ~redirect_valid;

  // A slot freed by this cycle's pop is credited immediately, which is what
  // lets a 1-cycle memory sustain one instruction per cycle at DEPTH=2.
  assign has_credit = ({1'b0, fifo_count} + {1'b0, outst_q})
                      < (DEPTH_W + {{CW{1'b0}}, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FS_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT:  state_d = FS_FETCH;
      FS_FETCH: state_d = FS_FETCH;
      FS_DRAIN: if (discard_q == '0) state_d = FS_FETCH;
      default:  state_d = FS_BOOT;
    endcase
    if (redirect_valid)
      state_d = (state_q == FS_DRAIN || discard_d != '0) ? FS_DRAIN : FS_FETCH;
  end

  always_comb begin
    imem_req    = (state_q == FS_FETCH) & has_credit & ~redirect_valid;
    dbg_state_o = state_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(grant) - CW'(imem_rvalid);
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)  resp_pc_d  = resp_pc_q + 32'd4;
    if (imem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
    // Everything still in flight after this cycle's response belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      discard_d  = outst_q - CW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({resp_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = ~fifo_empty;
  assign instr_word  = fifo_head.word;
  assign instr_pc    = fifo_head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && fifo_full));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized in-order memory model and a queue of
// expected {pc, word} pairs derived from the program-order fetch rules.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req, imem_gnt, imem_rvalid;
  logic [31:0]  imem_addr, imem_rdata;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid, instr_ready;
  logic [31:0]  instr_word, instr_pc;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .dbg_state_o    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] fetch_exp;
  logic [31:0] grant_log[$];

  int          cyc = 0;
  int          delivered = 0;
  int          last_del_cyc = 0;
  logic [31:0] last_pc, last_word;
  int          gnt_prob = 100, rdy_prob = 100, lat_min = 1, lat_max = 1;
  bit          redir_now = 1'b0;
  logic [31:0] redir_target = 32'h0;
  bit          hs_at_redir = 1'b0;
  bit          prev_redir = 1'b0, prev_stall = 1'b0;
  logic [63:0] held;

  function automatic void sb_refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = {pc[31:2], 2'b00};
    sb_refill();
  endfunction

  // One clock cycle: drive at the falling edge, observe 1ns later.
  task automatic step();
    mreq_t r;
    @(negedge clk);
    cyc++;
    imem_gnt    = ($urandom_range(99) < gnt_prob);
    instr_ready = ($urandom_range(99) < rdy_prob);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    redir_now      = 1'b0;
    #1;
    if (prev_redir) check("redir_flush", 64'(instr_valid), 64'd0);
    else if (prev_stall) begin
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_hold", {instr_pc, instr_word}, held);
    end
    if (instr_valid && instr_ready) begin
      check("deliver", {instr_pc, instr_word}, exp_q.pop_front());
      sb_refill();
      delivered++;
      last_del_cyc = cyc;
      last_pc      = instr_pc;
      last_word    = instr_word;
    end
    prev_stall = instr_valid && !instr_ready && !redirect_valid;
    held       = {instr_pc, instr_word};
    if (imem_req && imem_gnt) begin
      check("fetch_addr", 64'(imem_addr), 64'(fetch_exp));
      grant_log.push_back(imem_addr);
      fetch_exp = fetch_exp + 32'd4;
      r.addr = imem_addr;
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      mem_q.push_back(r);
      check("credit_limit", 64'(mem_q.size() <= DEPTH), 64'd1);
    end
    if (redirect_valid) begin
      hs_at_redir = instr_valid && instr_ready;
      sb_restart(redirect_pc);
      fetch_exp = {redirect_pc[31:2], 2'b00};
    end
    prev_redir = redirect_valid;
  endtask

  task automatic wait_deliveries(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (delivered < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(delivered >= target), 64'd1);
  endtask

  initial begin
    int d0, first_cyc, n;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   64'(imem_req),    64'd0);
    check("rst_addr",  64'(imem_addr),   64'(RESET_PC));
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_word",  64'(instr_word),  64'd0);
    check("rst_pc",    64'(instr_pc),    64'd0);
    check("rst_state", 64'(dbg_state),   64'(FS_BOOT));

    // Boot cycle, then first request and back-to-back delivery
    @(negedge clk);
    rst_n = 1'b1;
    fetch_exp = RESET_PC;
    sb_restart(RESET_PC);
    #1;
    check("boot_req", 64'(imem_req), 64'd0);
    step();
    check("first_req",   64'(imem_req),  64'd1);
    check("first_state", 64'(dbg_state), 64'(FS_FETCH));
    wait_deliveries(1, 10, "first_timeout");
    check("first_pc",   64'(last_pc),   64'd0);
    check("first_word", 64'(last_word), 64'h0050_0093);
    first_cyc = last_del_cyc;
    wait_deliveries(4, 10, "b2b_timeout");
    check("b2b_cycles", 64'(last_del_cyc - first_cyc), 64'd3);

    // Decoder stall: buffer fills, requests stop, head held
    rdy_prob = 0;
    repeat (5) step();
    check("stall_req",  64'(imem_req),    64'd0);
    check("stall_full", 64'(instr_valid), 64'd1);
    rdy_prob = 100;
    repeat (6) step();

    // Redirect with responses in flight
    lat_min = 4; lat_max = 4;
    n = 0;
    while (mem_q.size() < 2 && n < 20) begin step(); n++; end
    check("inflight_setup", 64'(mem_q.size()), 64'd2);
    redir_now = 1'b1; redir_target = 32'h100;
    step();
    step();
    check("drain_state", 64'(dbg_state), 64'(FS_DRAIN));
    d0 = delivered;
    wait_deliveries(d0 + 1, 30, "drain_timeout");
    check("drain_pc", 64'(last_pc), 64'h100);

    // Redirect coincident with a handshake and a response
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    redir_now = 1'b1; redir_target = 32'h200;
    d0 = delivered;
    step();
    check("coinc_hs",    64'(hs_at_redir), 64'd1);
    check("coinc_count", 64'(delivered),   64'(d0 + 1));
    wait_deliveries(d0 + 2, 20, "coinc_timeout");
    check("coinc_pc", 64'(last_pc), 64'h200);

    // PC wrap and redirect alignment
    repeat (3) step();
    grant_log.delete();
    redir_now = 1'b1; redir_target = 32'hFFFF_FFFC;
    step();
    n = 0;
    while (grant_log.size() < 2 && n < 20) begin step(); n++; end
    check("wrap_a", 64'(grant_log.size() > 0 ? grant_log[0] : 32'h1), 64'hFFFF_FFFC);
    check("wrap_b", 64'(grant_log.size() > 1 ? grant_log[1] : 32'h1), 64'h0);
    repeat (4) step();
    grant_log.delete();
    redir_now = 1'b1; redir_target = 32'h103;
    step();
    n = 0;
    while (grant_log.size() < 1 && n < 20) begin step(); n++; end
    check("align", 64'(grant_log.size() > 0 ? grant_log[0] : 32'h1), 64'h100);

    // Random grants, latencies, stalls and redirects
    gnt_prob = 70; rdy_prob = 70; lat_min = 1; lat_max = 4;
    d0 = delivered;
    n = 0;
    while (delivered - d0 < 1000 && n < 20000) begin
      if ($urandom_range(63) == 0) begin
        redir_now    = 1'b1;
        redir_target = $urandom;
      end
      step();
      n++;
    end
    check("random_count", 64'(delivered - d0 >= 1000), 64'd1);

    // Asynchronous reset mid-operation
    rdy_prob = 0; gnt_prob = 100; lat_min = 1; lat_max = 1;
    repeat (6) step();
    check("pre_rst_valid", 64'(instr_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_req",   64'(imem_req),    64'd0);
    check("async_state", 64'(dbg_state),   64'(FS_BOOT));
    check("async_addr",  64'(imem_addr),   64'(RESET_PC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
